// File: rtl/tcdm_bank_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM bank port among NumIn masters, with a
// RespLat-deep winner-index pipeline that routes response valids back.

module tcdm_bank_rr_arbiter_checker #(
    parameter int NumIn   = 8,
    parameter int RespLat = 1
) (
    input logic             clk_i,
    input logic             rst_ni,
    input logic [NumIn-1:0] req_i,
    input logic [NumIn-1:0] gnt_o,
    input logic [NumIn-1:0] vld_o
);
    a_params: assert property (@(posedge clk_i) (RespLat > 0) && (NumIn > 0))
        else $fatal(1, "tcdm_bank_rr_arbiter: RespLat and NumIn must be positive");
    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
    a_vld_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(vld_o));
    a_gnt_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((gnt_o & ~req_i) == {NumIn{1'b0}}));
endmodule

module tcdm_bank_rr_arbiter #(
    parameter int NumIn         = 8,
    parameter int ReqDataWidth  = 32,
    parameter int RespDataWidth = 32,
    parameter int RespLat       = 1,
    parameter int WriteRespOn   = 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumIn-1:0]                     req_i,
    input  logic [NumIn-1:0]                     wen_i,
    input  logic [NumIn-1:0][ReqDataWidth-1:0]   data_i,
    output logic [NumIn-1:0]                     gnt_o,
    output logic [NumIn-1:0]                     vld_o,
    output logic [RespDataWidth-1:0]             rdata_o,
    output logic                                 req_o,
    output logic                                 wen_o,
    output logic [ReqDataWidth-1:0]              data_o,
    input  logic                                 gnt_i,
    input  logic [RespDataWidth-1:0]             rdata_i
);
    localparam int IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;

    logic [IdxW-1:0] rr_q;
    logic [IdxW-1:0] rr_nxt_s;
    logic [IdxW-1:0] winner_s;
    logic            found_s;
    logic            hs_s;
    logic            resp_v_s;
    logic            v_q   [RespLat];
    logic [IdxW-1:0] idx_q [RespLat];

    // Scan requests starting at the priority pointer, wrapping at NumIn.
    always_comb begin
        winner_s = rr_q;
        found_s  = 1'b0;
        for (int i = 0; i < NumIn; i++) begin
            int raw;
            int cand;
            raw  = int'(rr_q) + i;
            cand = (raw >= NumIn) ? (raw - NumIn) : raw;
            if (!found_s && req_i[cand]) begin
                found_s  = 1'b1;
                winner_s = IdxW'(cand);
            end else begin
                found_s  = found_s;
            end
        end
    end

    assign req_o    = |req_i;
    assign wen_o    = wen_i[winner_s];
    assign data_o   = data_i[winner_s];
    assign hs_s     = req_o & gnt_i;
    assign rdata_o  = rdata_i;
    assign resp_v_s = hs_s & (~wen_o | (WriteRespOn != 0));
    // Explicit wrap keeps the pointer inside 0..NumIn-1 for non-power-of-two NumIn.
    assign rr_nxt_s = (winner_s == IdxW'(NumIn - 1)) ? {IdxW{1'b0}} : (winner_s + IdxW'(1));

    // Grant decode: only the winner can see the bank grant.
    always_comb begin
        gnt_o           = {NumIn{1'b0}};
        gnt_o[winner_s] = hs_s;
    end

    // Priority pointer advances past the winner only on a handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= {IdxW{1'b0}};
        end else if (hs_s) begin
            rr_q <= rr_nxt_s;
        end else begin
            rr_q <= rr_q;
        end
    end

    // Response pipeline: one entry per cycle, so ordering is implicit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RespLat; i++) begin
                v_q[i]   <= 1'b0;
                idx_q[i] <= {IdxW{1'b0}};
            end
        end else begin
            v_q[0]   <= resp_v_s;
            idx_q[0] <= winner_s;
            for (int i = 1; i < RespLat; i++) begin
                v_q[i]   <= v_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    // Route the last stage's valid to the master that issued it.
    always_comb begin
        vld_o                       = {NumIn{1'b0}};
        vld_o[idx_q[RespLat-1]]     = v_q[RespLat-1];
    end

    tcdm_bank_rr_arbiter_checker #(
        .NumIn   (NumIn),
        .RespLat (RespLat)
    ) u_checker (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req_i),
        .gnt_o  (gnt_o),
        .vld_o  (vld_o)
    );
endmodule

// File: tb/tb_tcdm_bank_rr_arbiter.sv
// Three arbiter configurations driven side by side and compared every cycle
// against a round-robin / response-schedule model.

module tb_tcdm_bank_rr_arbiter;
    logic clk;
    logic rst_n;

    logic [7:0]       req_v  [3];
    logic [7:0]       wen_v  [3];
    logic             gi_v   [3];
    logic [7:0][31:0] dat_v  [3];
    logic [31:0]      rdata_in;

    logic [7:0]  gnt_w   [3];
    logic [7:0]  vld_w   [3];
    logic        reqo_w  [3];
    logic        weno_w  [3];
    logic [31:0] datao_w [3];
    logic [31:0] rdata_w [3];

    logic [7:0]  gnt_a, vld_a, gnt_c, vld_c;
    logic [2:0]  gnt_b, vld_b;
    logic [2:0][31:0] datab_in;

    int n_m   [3] = '{8, 3, 8};
    int lat_m [3] = '{1, 2, 3};
    int wr_m  [3] = '{1, 1, 0};
    int rr_m  [3];
    int ring  [3][16];
    int cyc;
    int tests;
    int fails;

    assign datab_in = dat_v[1][2:0];

    tcdm_bank_rr_arbiter #(.NumIn(8), .ReqDataWidth(32), .RespDataWidth(32),
                           .RespLat(1), .WriteRespOn(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_v[0]), .wen_i(wen_v[0]),
        .data_i(dat_v[0]), .gnt_o(gnt_a), .vld_o(vld_a), .rdata_o(rdata_w[0]),
        .req_o(reqo_w[0]), .wen_o(weno_w[0]), .data_o(datao_w[0]),
        .gnt_i(gi_v[0]), .rdata_i(rdata_in));

    tcdm_bank_rr_arbiter #(.NumIn(3), .ReqDataWidth(32), .RespDataWidth(32),
                           .RespLat(2), .WriteRespOn(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_v[1][2:0]), .wen_i(wen_v[1][2:0]),
        .data_i(datab_in), .gnt_o(gnt_b), .vld_o(vld_b), .rdata_o(rdata_w[1]),
        .req_o(reqo_w[1]), .wen_o(weno_w[1]), .data_o(datao_w[1]),
        .gnt_i(gi_v[1]), .rdata_i(rdata_in));

    tcdm_bank_rr_arbiter #(.NumIn(8), .ReqDataWidth(32), .RespDataWidth(32),
                           .RespLat(3), .WriteRespOn(0)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_v[2]), .wen_i(wen_v[2]),
        .data_i(dat_v[2]), .gnt_o(gnt_c), .vld_o(vld_c), .rdata_o(rdata_w[2]),
        .req_o(reqo_w[2]), .wen_o(weno_w[2]), .data_o(datao_w[2]),
        .gnt_i(gi_v[2]), .rdata_i(rdata_in));

    assign gnt_w[0] = gnt_a;
    assign vld_w[0] = vld_a;
    assign gnt_w[1] = {5'b00000, gnt_b};
    assign vld_w[1] = {5'b00000, vld_b};
    assign gnt_w[2] = gnt_c;
    assign vld_w[2] = vld_c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[dut%0d] cyc=%0d: got %h, expected %h", nm, k, cyc, act, exp);
        end
    endtask

    // Reference model: per-cycle winner from the pointer, responses scheduled by cycle number.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int win;
            int slot;
            logic [7:0] eg;
            logic [7:0] ev;
            if (!rst_n) begin
                rr_m[k] = 0;
                for (int s = 0; s < 16; s++) ring[k][s] = -1;
            end
            win = -1;
            for (int j = 0; j < n_m[k]; j++) begin
                int idx;
                idx = (rr_m[k] + j) % n_m[k];
                if (win < 0 && req_v[k][idx]) win = idx;
            end
            eg   = (win >= 0 && gi_v[k]) ? 8'(1 << win) : 8'h00;
            slot = cyc % 16;
            ev   = (ring[k][slot] >= 0) ? 8'(1 << ring[k][slot]) : 8'h00;
            ring[k][slot] = -1;
            chk("gnt", k, {24'h0, gnt_w[k]}, {24'h0, eg});
            chk("vld", k, {24'h0, vld_w[k]}, {24'h0, ev});
            chk("req_o", k, {31'h0, reqo_w[k]}, {31'h0, (win >= 0)});
            chk("rdata", k, rdata_w[k], rdata_in);
            if (win >= 0) begin
                chk("wen_o", k, {31'h0, weno_w[k]}, {31'h0, wen_v[k][win]});
                chk("data_o", k, datao_w[k], dat_v[k][win]);
            end
            if (rst_n && win >= 0 && gi_v[k]) begin
                rr_m[k] = (win == n_m[k] - 1) ? 0 : win + 1;
                if (!wen_v[k][win] || wr_m[k] != 0)
                    ring[k][(cyc + lat_m[k]) % 16] = win;
            end
        end
        cyc++;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        rdata_in = $urandom;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        rst_n = 1'b0;
        rdata_in = 32'h0;
        for (int k = 0; k < 3; k++) begin
            req_v[k] = 8'h00;
            wen_v[k] = 8'h00;
            gi_v[k]  = 1'b1;
            for (int i = 0; i < 8; i++) dat_v[k][i] = $urandom;
            for (int s = 0; s < 16; s++) ring[k][s] = -1;
            rr_m[k] = 0;
        end
        repeat (2) begin
            @(negedge clk);
            chk("lit_reset_vld", 0, {24'h0, vld_w[0]}, 32'h0);
        end
        next_cycle();
        rst_n = 1'b1;

        // step 1
        next_cycle();
        req_v[0] = 8'h01; wen_v[0] = 8'h00;
        req_v[1] = 8'h05; wen_v[1] = 8'h00;
        req_v[2] = 8'h02; wen_v[2] = 8'h02;
        @(negedge clk);
        chk("lit_a_first_gnt", 0, {24'h0, gnt_w[0]}, 32'h01);
        chk("lit_c_write_gnt", 2, {24'h0, gnt_w[2]}, 32'h02);
        chk("lit_b_gnt0", 1, {24'h0, gnt_w[1]}, 32'h01);
        // step 2
        next_cycle();
        req_v[0] = 8'h03;
        req_v[2] = 8'h40; wen_v[2] = 8'h00;
        @(negedge clk);
        chk("lit_a_vld", 0, {24'h0, vld_w[0]}, 32'h01);
        chk("lit_a_rr1", 0, {24'h0, gnt_w[0]}, 32'h02);
        chk("lit_c_read_gnt", 2, {24'h0, gnt_w[2]}, 32'h40);
        chk("lit_b_gnt2", 1, {24'h0, gnt_w[1]}, 32'h04);
        // step 3
        next_cycle();
        req_v[0] = 8'h10;
        req_v[2] = 8'h00;
        @(negedge clk);
        chk("lit_a_gnt4", 0, {24'h0, gnt_w[0]}, 32'h10);
        chk("lit_b_gnt0b", 1, {24'h0, gnt_w[1]}, 32'h01);
        // step 4: a write response would appear here if enabled
        next_cycle();
        req_v[0] = 8'h90;
        @(negedge clk);
        chk("lit_a_gnt7", 0, {24'h0, gnt_w[0]}, 32'h80);
        chk("lit_c_no_wr_vld", 2, {24'h0, vld_w[2]}, 32'h0);
        chk("lit_b_gnt2b", 1, {24'h0, gnt_w[1]}, 32'h04);
        // step 5
        next_cycle();
        @(negedge clk);
        chk("lit_a_wrap_gnt4", 0, {24'h0, gnt_w[0]}, 32'h10);
        chk("lit_c_rd_vld", 2, {24'h0, vld_w[2]}, 32'h40);
        // stall with req 0x0C
        next_cycle();
        req_v[0] = 8'h0C; gi_v[0] = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("lit_a_stall", 0, {24'h0, gnt_w[0]}, 32'h0);
            if (s < 2) next_cycle();
        end
        next_cycle();
        gi_v[0] = 1'b1;
        @(negedge clk);
        chk("lit_a_after_stall", 0, {24'h0, gnt_w[0]}, 32'h04);
        next_cycle();
        req_v[0] = 8'hFF;
        @(negedge clk);
        chk("lit_a_all_next", 0, {24'h0, gnt_w[0]}, 32'h08);
        repeat (8) next_cycle();
        req_v[0] = 8'h00;
        req_v[1] = 8'h00;

        // reset while a RespLat=3 read is in flight
        next_cycle();
        req_v[2] = 8'h40; wen_v[2] = 8'h00;
        @(negedge clk);
        chk("lit_c_inflight_gnt", 2, {24'h0, gnt_w[2]}, 32'h40);
        next_cycle();
        rst_n = 1'b0;
        req_v[2] = 8'h00;
        @(negedge clk);
        chk("lit_c_rst_vld", 2, {24'h0, vld_w[2]}, 32'h0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        req_v[2] = 8'h81;
        @(negedge clk);
        chk("lit_c_rr0", 2, {24'h0, gnt_w[2]}, 32'h01);
        chk("lit_c_no_vld", 2, {24'h0, vld_w[2]}, 32'h0);
        next_cycle();
        req_v[2] = 8'h00;
        @(negedge clk);
        chk("lit_c_no_vld2", 2, {24'h0, vld_w[2]}, 32'h0);

        // randomized traffic with occasional reset pulses
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            rst_n = ($urandom_range(0, 299) != 0);
            for (int k = 0; k < 3; k++) begin
                req_v[k] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                wen_v[k] = 8'($urandom);
                gi_v[k]  = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < 8; i++) dat_v[k][i] = $urandom;
            end
        end
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) req_v[k] = 8'h00;
        repeat (5) next_cycle();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
